// File: rtl/mod_503_pkg.sv
// Shared definitions for the mod-503 residue sequencer: modulus, residue width,
// FSM state encoding and the 2^k mod 503 helper used to build fold weights.
package mod_503_pkg;

  localparam int RES_W = 9;
  localparam logic [RES_W-1:0] MOD_503 = 9'd503;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [RES_W-1:0] pow2_mod(input int k);
    int r;
    r = 1;
    for (int i = 0; i < k; i++) begin
      r = (r * 2) % int'(MOD_503);
    end
    return RES_W'(r);
  endfunction

endpackage

// File: rtl/mod_503_step.sv
// One Horner step of the residue reduction: (acc*2^W + chunk) mod 503, purely
// combinational. Valid for acc < 503 and 9 <= W <= 60.
module mod_503_step
  import mod_503_pkg::*;
#(
  parameter int W       = 30,
  parameter int MODULUS = int'(MOD_503)
) (
  input  logic [RES_W:1] acc,
  input  logic [W:1]     chunk,
  output logic [RES_W:1] acc_next
);

  localparam int VW    = W + RES_W;
  localparam int NLIMB = (VW + RES_W - 1) / RES_W;
  localparam int PW    = NLIMB * RES_W;

  logic [PW-1:0] v;
  logic [23:0]   s1;
  logic [13:0]   s2;
  logic [9:0]    s3;

  // Three folds: weighted limb sum, then two 2^9 == 9 folds bring the value
  // below 2*503 so a single conditional subtract finishes the job.
  always_comb begin
    v  = PW'({acc, chunk});
    s1 = '0;
    for (int k = 0; k < NLIMB; k++) begin
      s1 = s1 + 24'(v[k*RES_W +: RES_W]) * 24'(pow2_mod(k * RES_W));
    end
    s2 = 14'(s1[8:0])
       + 14'(s1[17:9])  * 14'(pow2_mod(RES_W))
       + 14'(s1[23:18]) * 14'(pow2_mod(2 * RES_W));
    s3 = 10'(s2[8:0]) + 10'(s2[13:9]) * 10'(pow2_mod(RES_W));
    if (s3 >= 10'(MODULUS)) begin
      acc_next = RES_W'(s3 - 10'(MODULUS));
    end else begin
      acc_next = s3[8:0];
    end
  end

endmodule

// File: rtl/x_300_mod_503_seq.sv
// Multi-cycle X mod 503 sequencer: accepts a 300-bit operand, consumes it MSB-first
// one W-bit chunk per clock through a shared Horner step, then presents the residue.
module x_300_mod_503_seq
  import mod_503_pkg::*;
#(
  parameter int N_BITS  = 300,
  parameter int W       = 30,
  parameter int MODULUS = int'(MOD_503)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS:1]   X,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W:1]    R,
  output logic              busy
);

  localparam int NCHUNK = (N_BITS + W - 1) / W;
  localparam int SHW    = NCHUNK * W;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  state_t state, state_next;

  logic [SHW-1:0]   sh;
  logic [RES_W:1]   acc;
  logic [RES_W:1]   acc_next;
  logic [CNT_W-1:0] cnt;
  logic             last_chunk;

  assign last_chunk = (cnt == LAST);

  mod_503_step #(
    .W       (W),
    .MODULUS (MODULUS)
  ) u_step (
    .acc      (acc),
    .chunk    (sh[SHW-1 -: W]),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Handshake outputs decode straight from state so they never depend on inputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_chunk) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Zero-extending X into sh pads the MSB chunk, so the first chunk out is the top one.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      acc <= '0;
      cnt <= '0;
      R   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sh  <= SHW'(X);
            acc <= '0;
            cnt <= '0;
          end
        end
        RUN: begin
          acc <= acc_next;
          sh  <= sh << W;
          cnt <= cnt + CNT_W'(1);
          if (last_chunk) begin
            R <= acc_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
